// File: rtl/bin_to_bcd_pkg.sv
// Shared display-path definitions: converter FSM states and default sizing.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 16-bit binary needs 5 decimal digits (65535).
    localparam int DEFAULT_W      = 16;
    localparam int DEFAULT_DIGITS = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per cycle, MSB first.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);

    state_t                state;
    logic [W-1:0]          bin_reg;
    logic [DIGITS*4-1:0]   scratch;
    logic [DIGITS*4-1:0]   adj;
    logic [CW-1:0]         cnt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[g*4 +: 4]),
            .q (adj[g*4 +: 4])
        );
    end

    // bcd only changes in DONE, so partial conversions are never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            bin_reg <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_reg <= bin;
                        scratch <= '0;
                        cnt     <= CW'(W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, bin_reg} <= {adj, bin_reg} << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= scratch;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver pushes expected BCD, negedge monitor pops on done.
module tb_bin_to_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    int busy_run = 0;
    int last_busy = 0;
    bit done_prev = 1'b0;
    logic [19:0] held_bcd = '0;
    logic [19:0] exp_q[$];

    bin_to_bcd #(.W(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit nibbles_ok(input logic [19:0] b);
        for (int i = 0; i < 5; i++)
            if (b[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [15:0] v, input logic [19:0] e, input bit push);
        wait_idle();
        start = 1'b1;
        bin   = v;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        acc_cyc = cyc;
        start = 1'b0;
        bin   = ~v;
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
        if (busy === 1'b1 && !rst) check("bcd_hold", {12'd0, bcd}, {12'd0, held_bcd});
        if (done_prev) check("done_width", {31'd0, done}, 32'd0);
        if (done === 1'b1) begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done with bcd %h required no done", bcd);
            end else begin
                check("bcd_value", {12'd0, bcd}, {12'd0, exp_q.pop_front()});
            end
            check("bcd_nibbles", {31'd0, nibbles_ok(bcd)}, 32'd1);
            check("busy_width", last_busy, 32'd17);
            held_bcd = bcd;
        end
        if (rst) held_bcd = '0;
        done_prev = (done === 1'b1);
    end

    // stimulus
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {12'd0, bcd}, 32'd0);

        // first start at the first edge with rst low; bin=0 latency
        rst = 1'b0;
        issue(16'd0, 20'h00000, 1'b1);
        drain();
        check("done_latency", last_done_cyc - acc_cyc, 32'd17);

        issue(16'd65535, 20'h65535, 1'b1);
        issue(16'd9999,  20'h09999, 1'b1);
        issue(16'd1,     20'h00001, 1'b1);
        drain();

        // start held during busy is ignored
        issue(16'd1234, 20'h01234, 1'b1);
        start = 1'b1;
        bin   = 16'd4321;
        repeat (10) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("held_start_ignored", {31'd0, busy}, 32'd0);
        check("held_start_bcd", {12'd0, bcd}, 32'h01234);

        // back-to-back: start in the done cycle
        issue(16'd1234, 20'h01234, 1'b1);
        wait_done();
        issue(16'd100, 20'h00100, 1'b1);
        drain();
        check("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd18);

        // reset aborts a conversion mid-way
        issue(16'd5000, 20'h05000, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcd", {12'd0, bcd}, 32'd0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_bcd_later", {12'd0, bcd}, 32'd0);
        issue(16'd42, 20'h00042, 1'b1);
        drain();

        // sweep against the decimal reference model
        for (int i = 0; i < 1000; i++) begin
            int v;
            v = int'($urandom_range(0, 65535));
            issue(16'(v), ref_bcd(v), 1'b1);
        end
        drain();
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
